// File: rtl/hdmi_video_timing.sv
// 720p60 raster timing generator: counters, sync, data-enable, line/frame markers
// and a per-line prefetch request for the upscaler line buffer.
module hdmi_video_timing #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int PREFETCH = 64
) (
  input  logic        clk_pixel,
  input  logic        resetn,
  output logic [11:0] cx,
  output logic [10:0] cy,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic        line_start,
  output logic        line_req,
  output logic [10:0] line_req_y
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] CX_LAST  = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] REQ_CX   = 12'(H_TOTAL - PREFETCH);
  localparam logic [10:0] CY_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] r_cx;
  logic [10:0] r_cy;
  logic        r_de, r_hsync, r_vsync, r_frame_start, r_line_start, r_line_req;
  logic [10:0] r_line_req_y;

  logic [11:0] w_cx_nxt;
  logic [10:0] w_cy_nxt, w_ny_nxt;
  logic        w_de_nxt, w_hs_act, w_vs_act, w_req_nxt;

  // Every output is decoded from the next counter values so that the registered
  // flags line up with the registered cx/cy they describe.
  always_comb begin
    w_cx_nxt = (r_cx == CX_LAST) ? 12'd0 : r_cx + 12'd1;
    w_cy_nxt = r_cy;
    if (r_cx == CX_LAST) begin
      w_cy_nxt = (r_cy == CY_LAST) ? 11'd0 : r_cy + 11'd1;
    end
    w_ny_nxt  = (w_cy_nxt == CY_LAST) ? 11'd0 : w_cy_nxt + 11'd1;
    w_de_nxt  = (w_cx_nxt < H_ACT) && (w_cy_nxt < V_ACT);
    w_hs_act  = (w_cx_nxt >= HS_START) && (w_cx_nxt < HS_END);
    w_vs_act  = (w_cy_nxt >= VS_START) && (w_cy_nxt < VS_END);
    w_req_nxt = (w_cx_nxt == REQ_CX) && (w_ny_nxt < V_ACT);
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk_pixel) begin
    if (!resetn) begin
      r_cx          <= CX_LAST;
      r_cy          <= CY_LAST;
      r_de          <= 1'b0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
      r_line_req    <= 1'b0;
      r_line_req_y  <= 11'd0;
    end else begin
      r_cx          <= w_cx_nxt;
      r_cy          <= w_cy_nxt;
      r_de          <= w_de_nxt;
      r_hsync       <= w_hs_act ? HS_POL : ~HS_POL;
      r_vsync       <= w_vs_act ? VS_POL : ~VS_POL;
      r_frame_start <= (w_cx_nxt == 12'd0) && (w_cy_nxt == 11'd0);
      r_line_start  <= (w_cx_nxt == 12'd0);
      r_line_req    <= w_req_nxt;
      if (w_req_nxt) begin
        r_line_req_y <= w_ny_nxt;
      end
    end
  end

  assign cx          = r_cx;
  assign cy          = r_cy;
  assign de          = r_de;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_frame_start;
  assign line_start  = r_line_start;
  assign line_req    = r_line_req;
  assign line_req_y  = r_line_req_y;

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Bench for hdmi_video_timing: a reduced raster (both sync polarities) and the full
// 720p raster, compared each cycle against a position-from-elapsed-time model.
module tb_hdmi_video_timing;

  // Reduced raster: H_TOTAL = 28, V_TOTAL = 17, frame = 476 cycles, line_req at cx = 22.
  localparam int SHA = 16, SHF = 4, SHS = 3, SHB = 5;
  localparam int SVA = 10, SVF = 2, SVS = 2, SVB = 3;
  localparam int SPF = 6;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;
  localparam int SFRAME = SHT * SVT;

  typedef struct packed {
    logic [11:0] cx;
    logic [10:0] cy;
    logic        de, hs, vs, fs, ls, req;
    logic [10:0] req_y;
  } vid_t;

  logic clk_pixel = 1'b0;
  logic resetn    = 1'b0;
  int   t         = -2;  // cycles since reset release; -1 while in reset, -2 before any reset edge
  int   n_checks  = 0;
  int   n_fail    = 0;

  logic [11:0] s_cx, v_cx, f_cx;
  logic [10:0] s_cy, v_cy, f_cy, s_ry, v_ry, f_ry;
  logic s_de, s_hs, s_vs, s_fs, s_ls, s_rq;
  logic v_de, v_hs, v_vs, v_fs, v_ls, v_rq;
  logic f_de, f_hs, f_vs, f_fs, f_ls, f_rq;

  always #5 clk_pixel = ~clk_pixel;

  hdmi_video_timing #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .HS_POL(1'b1), .VS_POL(1'b1), .PREFETCH(SPF)
  ) u_small (
    .clk_pixel(clk_pixel), .resetn(resetn), .cx(s_cx), .cy(s_cy), .de(s_de),
    .hsync(s_hs), .vsync(s_vs), .frame_start(s_fs), .line_start(s_ls),
    .line_req(s_rq), .line_req_y(s_ry)
  );

  hdmi_video_timing #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .HS_POL(1'b0), .VS_POL(1'b0), .PREFETCH(SPF)
  ) u_inv (
    .clk_pixel(clk_pixel), .resetn(resetn), .cx(v_cx), .cy(v_cy), .de(v_de),
    .hsync(v_hs), .vsync(v_vs), .frame_start(v_fs), .line_start(v_ls),
    .line_req(v_rq), .line_req_y(v_ry)
  );

  hdmi_video_timing u_full (
    .clk_pixel(clk_pixel), .resetn(resetn), .cx(f_cx), .cy(f_cy), .de(f_de),
    .hsync(f_hs), .vsync(f_vs), .frame_start(f_fs), .line_start(f_ls),
    .line_req(f_rq), .line_req_y(f_ry)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %0d, expected %0d", name, t, act, exp);
    end
  endtask

  // Expected outputs at elapsed time t, derived straight from the raster rules.
  function automatic vid_t model(input int tt, input int ha, input int hfp, input int hsw,
                                 input int hbp, input int va, input int vfp, input int vsw,
                                 input int vbp, input int pf, input bit hpol, input bit vpol,
                                 input logic [10:0] held);
    int ht, vt, x, y, ny;
    vid_t e;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    if (tt < 0) begin
      e = '{cx: 12'(ht - 1), cy: 11'(vt - 1), de: 1'b0, hs: ~hpol, vs: ~vpol,
            fs: 1'b0, ls: 1'b0, req: 1'b0, req_y: 11'd0};
    end else begin
      x  = tt % ht;
      y  = (tt / ht) % vt;
      ny = (y + 1) % vt;
      e.cx    = 12'(x);
      e.cy    = 11'(y);
      e.de    = (x < ha) && (y < va);
      e.hs    = (x >= ha + hfp && x < ha + hfp + hsw) ? hpol : ~hpol;
      e.vs    = (y >= va + vfp && y < va + vfp + vsw) ? vpol : ~vpol;
      e.fs    = (x == 0) && (y == 0);
      e.ls    = (x == 0);
      e.req   = (x == ht - pf) && (ny < va);
      e.req_y = e.req ? 11'(ny) : held;
    end
    return e;
  endfunction

  task automatic cmp_vid(input string tag, input vid_t a, input vid_t e);
    check({tag, ".cx"},          int'(a.cx),    int'(e.cx));
    check({tag, ".cy"},          int'(a.cy),    int'(e.cy));
    check({tag, ".de"},          int'(a.de),    int'(e.de));
    check({tag, ".hsync"},       int'(a.hs),    int'(e.hs));
    check({tag, ".vsync"},       int'(a.vs),    int'(e.vs));
    check({tag, ".frame_start"}, int'(a.fs),    int'(e.fs));
    check({tag, ".line_start"},  int'(a.ls),    int'(e.ls));
    check({tag, ".line_req"},    int'(a.req),   int'(e.req));
    check({tag, ".line_req_y"},  int'(a.req_y), int'(e.req_y));
  endtask

  always @(posedge clk_pixel) begin
    if (!resetn)     t <= -1;
    else if (t >= -1) t <= t + 1;
  end

  logic [10:0] held_s = 11'd0, held_v = 11'd0, held_f = 11'd0;

  always @(negedge clk_pixel) begin : compare
    vid_t es, ev, ef;
    if (t >= -1) begin
      es = model(t, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, SPF, 1'b1, 1'b1, held_s);
      ev = model(t, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, SPF, 1'b0, 1'b0, held_v);
      ef = model(t, 1280, 110, 40, 220, 720, 5, 5, 20, 64, 1'b1, 1'b1, held_f);
      held_s <= es.req_y;
      held_v <= ev.req_y;
      held_f <= ef.req_y;
      cmp_vid("small", '{s_cx, s_cy, s_de, s_hs, s_vs, s_fs, s_ls, s_rq, s_ry}, es);
      cmp_vid("inv",   '{v_cx, v_cy, v_de, v_hs, v_vs, v_fs, v_ls, v_rq, v_ry}, ev);
      cmp_vid("full",  '{f_cx, f_cy, f_de, f_hs, f_vs, f_fs, f_ls, f_rq, f_ry}, ef);
    end
  end

  initial begin
    int s_de_cnt, s_vs_cnt, s_rq_cnt, s_fs_cnt, s_vs_rise, v_hs_low, v_vs_low;
    int f_de_cnt, f_hs_cnt;
    bit found;
    s_de_cnt = 0; s_vs_cnt = 0; s_rq_cnt = 0; s_fs_cnt = 0; s_vs_rise = -1;
    v_hs_low = 0; v_vs_low = 0; f_de_cnt = 0; f_hs_cnt = 0;

    resetn = 1'b0;
    repeat (10) @(posedge clk_pixel);
    @(negedge clk_pixel);
    // Last reset cycle: hand-computed reset state.
    check("rst.full.cx", int'(f_cx), 1649);
    check("rst.full.cy", int'(f_cy), 749);
    check("rst.full.de", int'(f_de), 0);
    check("rst.inv.hsync_idle", int'(v_hs), 1);
    resetn = 1'b1;

    for (int k = 0; k < 3400; k++) begin
      @(negedge clk_pixel);
      if (t < SFRAME) begin
        s_de_cnt += int'(s_de);
        s_vs_cnt += int'(s_vs);
        s_rq_cnt += int'(s_rq);
        s_fs_cnt += int'(s_fs);
        v_vs_low += int'(!v_vs);
        if (s_vs && s_vs_rise < 0) s_vs_rise = t;
      end
      if (t < SHT) v_hs_low += int'(!v_hs);
      if (t < 1650) begin
        f_de_cnt += int'(f_de);
        f_hs_cnt += int'(f_hs);
      end
      case (t)
        0: begin
          check("first.full.cx", int'(f_cx), 0);
          check("first.full.cy", int'(f_cy), 0);
          check("first.full.de", int'(f_de), 1);
          check("first.full.frame_start", int'(f_fs), 1);
          check("first.full.hsync", int'(f_hs), 0);
          check("first.full.vsync", int'(f_vs), 0);
          check("first.inv.vsync", int'(v_vs), 1);
        end
        22:   begin check("small.req@cy0", int'(s_rq), 1); check("small.req_y@cy0", int'(s_ry), 1); end
        246:  begin check("small.req@cy8", int'(s_rq), 1); check("small.req_y@cy8", int'(s_ry), 9); end
        274:  check("small.noreq@cy9", int'(s_rq), 0);
        470:  begin check("small.req@cy16", int'(s_rq), 1); check("small.req_y@cy16", int'(s_ry), 0); end
        476:  check("small.frame_start_period", int'(s_fs), 1);
        1279: check("full.de@1279", int'(f_de), 1);
        1280: check("full.de@1280", int'(f_de), 0);
        1389: check("full.hsync@1389", int'(f_hs), 0);
        1390: check("full.hsync@1390", int'(f_hs), 1);
        1430: check("full.hsync@1430", int'(f_hs), 0);
        1586: begin check("full.req@1586", int'(f_rq), 1); check("full.req_y@1586", int'(f_ry), 1); end
        1650: begin check("full.line_start@1650", int'(f_ls), 1); check("full.cy@1650", int'(f_cy), 1); end
        default: ;
      endcase
    end

    check("small.de_count",     s_de_cnt, 160);
    check("small.vsync_count",  s_vs_cnt, 56);
    check("small.vsync_rise_t", s_vs_rise, 336);
    check("small.req_count",    s_rq_cnt, 10);
    check("small.fs_count",     s_fs_cnt, 1);
    check("inv.hsync_low_line", v_hs_low, 3);
    check("inv.vsync_low_frame", v_vs_low, 56);
    check("full.de_count_line0", f_de_cnt, 1280);
    check("full.hsync_count_line0", f_hs_cnt, 40);

    // Mid-frame reset with the reduced raster at cx=10, cy=5.
    found = 1'b0;
    for (int k = 0; k < 2 * SFRAME && !found; k++) begin
      @(negedge clk_pixel);
      if (t % SFRAME == 5 * SHT + 10) found = 1'b1;
    end
    check("midreset.position_reached", int'(found), 1);
    check("midreset.small.cx_before", int'(s_cx), 10);
    resetn = 1'b0;
    @(negedge clk_pixel);
    check("midreset.small.cx", int'(s_cx), 27);
    check("midreset.small.cy", int'(s_cy), 16);
    check("midreset.small.req_y", int'(s_ry), 0);
    check("midreset.full.cx", int'(f_cx), 1649);
    resetn = 1'b1;
    @(negedge clk_pixel);
    check("restart.small.cx", int'(s_cx), 0);
    check("restart.small.cy", int'(s_cy), 0);
    check("restart.small.frame_start", int'(s_fs), 1);
    check("restart.full.de", int'(f_de), 1);
    repeat (600) @(negedge clk_pixel);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
